// File: rtl/ula_seq_ctrl.sv
// rtl/ula_seq_ctrl.sv - nibble-serial sequencer driving an external 4-bit ALU slice
//
// Runs one W-bit ALU operation (W = 4*NIBBLES) through a single 4-bit slice.
// It processes one nibble per cycle, starting with the least significant nibble.
// The carry ripples through an internal carry register.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_a, req_b             W-bit operands
//   req_s, req_m, req_cin    function select, mode (1 = logic), true carry-in
//   alu_a, alu_b             nibble operands to the slice (zero when not running)
//   alu_s, alu_m, alu_cin    select, mode and carry to the slice (zero when not running)
//   alu_f, alu_cout, alu_eq  slice result, true carry-out, nibble equality
//   rsp_valid / rsp_ready    response handshake
//   rsp_f, rsp_cout          W-bit result and final carry
//   rsp_eq, rsp_zero         full-word a==b, result==0

module ula_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    input  logic [3:0]             req_s,
    input  logic                   req_m,
    input  logic                   req_cin,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cin,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cout,
    input  logic                   alu_eq,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_f,
    output logic                   rsp_cout,
    output logic                   rsp_eq,
    output logic                   rsp_zero
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic [3:0]      s_q;
    logic            m_q;
    logic            carry_q;
    logic            eq_q;
    logic [IW-1:0]   idx_q;
    logic            last;

    assign last = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_s     = 4'h0;
        alu_m     = 1'b0;
        alu_cin   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_a   = a_q[{idx_q, 2'b00} +: 4];
                alu_b   = b_q[{idx_q, 2'b00} +: 4];
                alu_s   = s_q;
                alu_m   = m_q;
                alu_cin = carry_q;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                // DONE does not accept a request, so the handshake cycle is always a bubble.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= 4'h0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q     <= req_a;
                        b_q     <= req_b;
                        s_q     <= req_s;
                        m_q     <= req_m;
                        carry_q <= req_cin;
                        idx_q   <= '0;
                        eq_q    <= 1'b1;
                    end
                end
                RUN: begin
                    res_q[{idx_q, 2'b00} +: 4] <= alu_f;
                    // The slice returns cout 0 in logic mode, so the ripple needs no mode special case.
                    carry_q <= alu_cout;
                    eq_q    <= eq_q & alu_eq;
                    if (!last) begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_f    = res_q;
    assign rsp_cout = carry_q;
    assign rsp_eq   = eq_q;
    // Gated by DONE so that it reads 0 after reset while the cleared result is zero.
    assign rsp_zero = (state_q == DONE) && (res_q == '0);

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// tb/tb_ula_seq_ctrl.sv - self-checking bench for ula_seq_ctrl with a behavioural 4-bit slice

module tb_ula_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [3:0]   req_s = 4'h0;
    logic         req_m = 1'b0;
    logic         req_cin = 1'b0;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cin;
    logic [3:0]   alu_f;
    logic         alu_cout;
    logic         alu_eq;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_f;
    logic         rsp_cout;
    logic         rsp_eq;
    logic         rsp_zero;

    int vectors = 0;
    int miscompares = 0;
    logic checking = 1'b0;

    always #5 clk = ~clk;

    ula_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_eq(alu_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_eq(rsp_eq), .rsp_zero(rsp_zero)
    );

    // Behavioural 4-bit slice: add (1001), subtract-with-carry (0110), logic XOR (0110, m=1).
    logic [4:0] alu_t;
    always_comb begin
        alu_t = 5'h0;
        if (!alu_m && alu_s == 4'b1001)
            alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
        else if (!alu_m && alu_s == 4'b0110)
            alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'h0, alu_cin};
        else if (alu_m && alu_s == 4'b0110)
            alu_t = {1'b0, alu_a ^ alu_b};
        else
            alu_t = {1'b0, alu_a};
        alu_f    = alu_t[3:0];
        alu_cout = alu_t[4];
        alu_eq   = (alu_a == alu_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference result {cout, f}.
    function automatic logic [W:0] word_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] s, input logic m, input logic cin);
        if (m)
            return {1'b0, a ^ b};
        else if (s == 4'b1001)
            return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        else
            return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
    endfunction

    // Model of the operation in flight, advanced from the stimulus only.
    logic         m_idle = 1'b1;
    logic         m_valid = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_f = '0;
    logic [3:0]   m_s = 4'h0;
    logic         m_m = 1'b0;
    logic         m_cin = 1'b0;
    logic         m_cout = 1'b0;
    logic         m_eq = 1'b0;

    // Carry entering nibble k is bit 4k of the sum of the lower 4k bits.
    function automatic logic exp_cin(input int k);
        logic [31:0] mask;
        logic [31:0] bop;
        logic [31:0] sum;
        if (k == 0) return m_cin;
        if (m_m) return 1'b0;
        mask = (32'd1 << (4 * k)) - 32'd1;
        bop  = (m_s == 4'b1001) ? {16'h0, m_b} : {16'h0, ~m_b};
        sum  = ({16'h0, m_a} & mask) + (bop & mask) + {31'h0, m_cin};
        return sum[4 * k];
    endfunction

    always @(posedge clk) begin
        logic [W:0] r;
        if (rst) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (m_idle) begin
            if (req_valid) begin
                m_a = req_a; m_b = req_b; m_s = req_s; m_m = req_m; m_cin = req_cin;
                r = word_op(req_a, req_b, req_s, req_m, req_cin);
                m_f = r[W-1:0];
                m_cout = r[W];
                m_eq = (req_a == req_b);
                m_idle = 1'b0;
                m_cnt = 0;
            end
        end else if (!m_valid) begin
            m_cnt++;
            if (m_cnt == N) m_valid = 1'b1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("req_ready", {31'h0, req_ready}, {31'h0, m_idle});
            check("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_valid});
            if (m_valid) begin
                check("rsp_f", {16'h0, rsp_f}, {16'h0, m_f});
                check("rsp_cout/eq/zero", {29'h0, rsp_cout, rsp_eq, rsp_zero},
                      {29'h0, m_cout, m_eq, (m_f == '0)});
            end
            if (!m_idle && !m_valid)
                check("alu_drive", {18'h0, alu_a, alu_b, alu_s, alu_m, alu_cin},
                      {18'h0, m_a[4*m_cnt +: 4], m_b[4*m_cnt +: 4], m_s, m_m, exp_cin(m_cnt)});
            else
                check("alu_idle", {18'h0, alu_a, alu_b, alu_s, alu_m, alu_cin}, 32'h0);
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic cin,
                          input logic [W-1:0] ef, input logic ec, input logic eeq,
                          input logic ez, input int bp);
        int   lat;
        logic got;
        req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin; req_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the request inputs; the running operation must ignore them.
        req_valid = 1'b0; req_a = ~a; req_b = a; req_s = ~s; req_m = ~m; req_cin = ~cin;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            got = rsp_valid;
        end
        check({name, " latency"}, lat, N);
        check({name, " f"}, {16'h0, rsp_f}, {16'h0, ef});
        check({name, " cout/eq/zero"}, {29'h0, rsp_cout, rsp_eq, rsp_zero}, {29'h0, ec, eeq, ez});
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            check({name, " hold f"}, {16'h0, rsp_f}, {16'h0, ef});
            check({name, " hold ready/valid"}, {30'h0, req_ready, rsp_valid}, 32'h1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({name, " after handshake"}, {30'h0, req_ready, rsp_valid}, 32'h2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        check("reset ready/valid", {30'h0, req_ready, rsp_valid}, 32'h2);
        check("reset rsp", {13'h0, rsp_f, rsp_cout, rsp_eq, rsp_zero}, 32'h0);

        run_op("add",      16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 0);
        run_op("overflow", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        run_op("sub_neg",  16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub_pos",  16'h0007, 16'h0005, 4'b0110, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 3);
        run_op("xor",      16'hA5A5, 16'hA5A5, 4'b0110, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 0);

        // Abandon an operation once it has reached nibble index 2.
        req_a = 16'h1111; req_b = 16'h2222; req_s = 4'b1001; req_m = 1'b0; req_cin = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun reset ready/valid", {30'h0, req_ready, rsp_valid}, 32'h2);
        check("midrun reset rsp", {13'h0, rsp_f, rsp_cout, rsp_eq, rsp_zero}, 32'h0);
        repeat (8) @(posedge clk);
        #1;

        run_op("add_after_rst", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0, 1);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
